// File: rtl/f_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : f_add_arbiter
// Description : Shares a single f_add floating-point adder between N_REQ
//               requesters. A round-robin arbiter grants at most one request
//               per cycle into a registered issue stage; the requester ID of
//               each in-flight operation is kept in an in-order tag FIFO so
//               that each adder result (and error flag) is strobed back to
//               the requester that issued it.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               req_valid/req_ready     - per-requester handshake
//               req_a/req_b             - packed operands, FLEN bits each
//               rsp_valid/res/error     - one-hot result strobe + shared data
//               fu_a/fu_b/fu_up_valid   - issue interface to the adder
//               fu_res/down_valid/busy/error - adder result interface
//               inflight                - outstanding operation count
//               proto_err               - sticky: result with no pending ID
// Revision    : 1.0 - initial release
// ============================================================================
module f_add_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLEN         = 64    // matches FLEN of the shared config
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*FLEN-1:0]         req_a,
    input  logic [N_REQ*FLEN-1:0]         req_b,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [FLEN-1:0]               rsp_res,
    output logic                          rsp_error,
    output logic [FLEN-1:0]               fu_a,
    output logic [FLEN-1:0]               fu_b,
    output logic                          fu_up_valid,
    input  logic [FLEN-1:0]               fu_res,
    input  logic                          fu_down_valid,
    input  logic                          fu_busy,
    input  logic                          fu_error,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          proto_err
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW  = $clog2(MAX_INFLIGHT);
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0]  c_max     = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0]  c_one     = CW'(1);
    localparam logic [IDW-1:0] c_ptr_rst = IDW'(N_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0]   r_ptr;                    // last granted requester
    logic [IDW-1:0]   r_fifo [MAX_INFLIGHT];    // in-order ID queue
    logic [CW-1:0]    r_wr_ptr;                 // extra MSB: full vs empty
    logic [CW-1:0]    r_rd_ptr;
    logic             r_fu_up;
    logic [FLEN-1:0]  r_fu_a;
    logic [FLEN-1:0]  r_fu_b;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [FLEN-1:0]  r_rsp_res;
    logic             r_rsp_error;
    logic             r_proto_err;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [CW-1:0]    w_count;
    logic             w_empty;
    logic             w_can_issue;
    logic             w_found;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_grant;
    logic             w_accept;
    logic             w_pop;
    logic [IDW-1:0]   w_head;
    logic [N_REQ-1:0] w_head_onehot;
    logic [N_REQ-1:0] w_ready;
    logic [FLEN-1:0]  w_a_arr [N_REQ];
    logic [FLEN-1:0]  w_b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*FLEN +: FLEN];
            assign w_b_arr[gi] = req_b[gi*FLEN +: FLEN];
        end
    endgenerate

    // Pointer difference is the FIFO occupancy, which is exactly inflight.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // The !r_fu_up term forces an idle cycle after every issue so the adder
    // has time to raise fu_busy before we consider issuing again. Gating by
    // rst keeps req_ready low while the block is being reset.
    assign w_can_issue = !rst && !fu_busy && !r_fu_up && (w_count < c_max);

    // Round-robin scan starting one past the last grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + 1 + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_accept = w_can_issue && w_found;

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    // A result with nothing outstanding is dropped (flagged via proto_err).
    assign w_pop  = fu_down_valid && !w_empty;
    assign w_head = r_fifo[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_head_onehot         = '0;
        w_head_onehot[w_head] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Control registers (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= c_ptr_rst;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fu_up     <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_error <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_fu_up     <= w_accept;
            r_rsp_valid <= w_pop ? w_head_onehot : '0;
            r_rsp_error <= w_pop && fu_error;
            if (w_accept) begin
                r_ptr    <= w_grant;
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            if (fu_down_valid && w_empty) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset needed; qualified by the strobes above)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fu_a                      <= w_a_arr[w_grant];
            r_fu_b                      <= w_b_arr[w_grant];
            r_fifo[r_wr_ptr[AW-1:0]]    <= w_grant;
        end
        if (w_pop) begin
            r_rsp_res <= fu_res;
        end
    end

    assign req_ready   = w_ready;
    assign fu_a        = r_fu_a;
    assign fu_b        = r_fu_b;
    assign fu_up_valid = r_fu_up;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_res     = r_rsp_res;
    assign rsp_error   = r_rsp_error;
    assign inflight    = w_count;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_f_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_f_add_arbiter
// Description : Self-checking bench for f_add_arbiter. A behavioural adder
//               (real arithmetic, fixed latency, optional hold-back) sits on
//               the fu_* side; a transaction-level reference model predicts
//               grants, in-flight count, routed responses and proto_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f_add_arbiter;

    localparam int N    = 4;
    localparam int MAXI = 4;
    localparam int FL   = 64;
    localparam int LAT  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*FL-1:0] req_a;
    logic [N*FL-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [FL-1:0]   rsp_res;
    logic            rsp_error;
    logic [FL-1:0]   fu_a;
    logic [FL-1:0]   fu_b;
    logic            fu_up_valid;
    logic [FL-1:0]   fu_res;
    logic            fu_down_valid;
    logic            fu_busy;
    logic            fu_error;
    logic [2:0]      inflight;
    logic            proto_err;

    f_add_arbiter #(.N_REQ(N), .MAX_INFLIGHT(MAXI), .FLEN(FL)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_res       (rsp_res),
        .rsp_error     (rsp_error),
        .fu_a          (fu_a),
        .fu_b          (fu_b),
        .fu_up_valid   (fu_up_valid),
        .fu_res        (fu_res),
        .fu_down_valid (fu_down_valid),
        .fu_busy       (fu_busy),
        .fu_error      (fu_error),
        .inflight      (inflight),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // IEEE double add; error means the sum is NaN (e.g. +inf + -inf).
    function automatic void fp_ref(input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] r, output logic e);
        real s;
        s = $bitstoreal(a) + $bitstoreal(b);
        r = $realtobits(s);
        e = (r[62:52] == 11'h7FF) && (r[51:0] != 52'd0);
    endfunction

    function automatic logic [63:0] rnd_fp();
        real v;
        v = real'($urandom_range(0, 4000)) / 8.0 - 250.0;
        return $realtobits(v);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural adder: fixed latency, in order, may hold results back
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] res;
        logic        err;
        int          due;
    } aop_t;

    aop_t aq[$];
    aop_t a_op;
    int   a_cyc = 0;
    logic [63:0] a_r;
    logic        a_e;
    logic hold;
    logic force_down;
    int   rel_req  = 0;
    int   rel_done = 0;

    always @(negedge clk) begin
        a_cyc++;
        fu_down_valid = 1'b0;
        if (rst) begin
            aq.delete();
        end else begin
            if (fu_up_valid) begin
                fp_ref(fu_a, fu_b, a_r, a_e);
                aq.push_back('{a_r, a_e, a_cyc + LAT});
            end
            if (force_down) begin
                fu_down_valid = 1'b1;
                fu_res        = {$urandom, $urandom};
                fu_error      = 1'b0;
            end else if (aq.size() > 0 && aq[0].due <= a_cyc &&
                         (!hold || rel_done < rel_req)) begin
                if (hold) rel_done++;
                a_op          = aq.pop_front();
                fu_down_valid = 1'b1;
                fu_res        = a_op.res;
                fu_error      = a_op.err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model (transaction level)
    // ------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [63:0] res;
        logic        err;
    } exp_t;

    exp_t        m_q[$];
    exp_t        m_e;
    int          m_last;
    bit          m_up;
    bit          m_proto;
    logic        exp_up;
    logic [N-1:0] exp_rsp_valid;
    logic [63:0] exp_res;
    logic        exp_err;
    logic [2:0]  exp_inflight;

    bit          rec_rr;
    logic [N-1:0] q_grants[$];
    bit          pp_seen;
    logic [N-1:0] last_ready;
    logic [N-1:0] last_v;
    logic [63:0] last_res;
    logic        last_err;

    function automatic int pick(input logic [N-1:0] v, input int last);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_eval();
        int          g;
        logic [N-1:0] er;
        logic [63:0] r;
        logic        e;
        int          pre;
        if (rst) begin
            chk("ready_in_rst", req_ready, '0);
            m_q.delete();
            m_last = N - 1;
            m_up = 0; m_proto = 0;
            exp_up = 0; exp_rsp_valid = '0; exp_inflight = '0;
            return;
        end
        pre = m_q.size();
        g   = -1;
        if (!fu_busy && !m_up && pre < MAXI) g = pick(req_valid, m_last);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        last_ready = req_ready;
        if (rec_rr && req_ready != '0) q_grants.push_back(req_ready);
        exp_rsp_valid = '0;
        if (fu_down_valid) begin
            if (pre == 0) begin
                m_proto = 1;
            end else begin
                m_e = m_q.pop_front();
                exp_rsp_valid[m_e.id] = 1'b1;
                exp_res = m_e.res;
                exp_err = m_e.err;
                if (g >= 0) pp_seen = 1;
            end
        end
        if (g >= 0) begin
            fp_ref(req_a[g*FL +: FL], req_b[g*FL +: FL], r, e);
            m_q.push_back('{g, r, e});
            m_last = g;
        end
        m_up = (g >= 0);
        exp_up = m_up;
        exp_inflight = 3'(m_q.size());
    endtask

    task automatic check_regs();
        chk("fu_up_valid", fu_up_valid, exp_up);
        chk("rsp_valid", rsp_valid, exp_rsp_valid);
        if (exp_rsp_valid != '0) begin
            chk("rsp_res", rsp_res, exp_res);
            chk("rsp_error", rsp_error, exp_err);
        end
        chk("inflight", inflight, exp_inflight);
        chk("proto_err", proto_err, m_proto);
        if (rsp_valid != '0) begin
            last_v = rsp_valid; last_res = rsp_res; last_err = rsp_error;
        end
    endtask

    // Called at posedge+1 with inputs for the coming cycle already driven.
    task automatic tick();
        @(negedge clk); #1;
        model_eval();
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*FL +: FL] = rnd_fp();
            req_b[i*FL +: FL] = rnd_fp();
        end
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [N-1:0] rr_exp [5];

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        fu_busy = 1'b0; hold = 1'b0; force_down = 1'b0;
        fu_res = '0; fu_error = 1'b0; fu_down_valid = 1'b0;
        rec_rr = 0; pp_seen = 0; last_v = '0; last_res = '0; last_err = 1'b0;
        last_ready = '0;
        m_last = N - 1; m_up = 0; m_proto = 0;
        exp_up = 0; exp_rsp_valid = '0; exp_inflight = '0; exp_res = '0; exp_err = 0;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        // Round robin from reset: all four requesters held valid
        rnd_ops();
        rec_rr = 1; last_v = '0;
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        rec_rr = 0;
        idle(10);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < q_grants.size()) ? q_grants[i] : 4'hx, rr_exp[i]);

        // Single issue: 1.0 + 2.0 from requester 0
        req_a[0 +: FL] = 64'h3FF0000000000000;
        req_b[0 +: FL] = 64'h4000000000000000;
        last_v = '0;
        req_valid = 4'b0001;
        tick();
        idle(8);
        chk("single_v",   last_v,   4'b0001);
        chk("single_res", last_res, 64'h4008000000000000);
        chk("single_err", last_err, 1'b0);
        chk("single_inflight", inflight, 3'd0);

        // Full: hold results, four accepts, then release one
        hold = 1'b1;
        rnd_ops();
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        chk("full_inflight", inflight, 3'd4);
        chk("full_ready", last_ready, 4'b0000);
        rel_req++;
        tick();
        chk("release_inflight", inflight, 3'd3);
        tick();
        chk("refill_inflight", inflight, 3'd4);
        hold = 1'b0;
        idle(14);

        // Simultaneous push and pop
        rnd_ops();
        req_valid = 4'b0011;
        for (int i = 0; i < 12; i++) tick();
        idle(10);
        chk("pushpop_seen", pp_seen, 1'b1);

        // Error path: +inf + -inf from requester 1
        req_a[1*FL +: FL] = 64'h7FF0000000000000;
        req_b[1*FL +: FL] = 64'hFFF0000000000000;
        last_v = '0;
        req_valid = 4'b0010;
        tick();
        idle(8);
        chk("err_v",   last_v,   4'b0010);
        chk("err_flag", last_err, 1'b1);

        // Protocol error, then reset with two operations outstanding
        force_down = 1'b1;
        tick();
        force_down = 1'b0;
        tick();
        chk("proto_set", proto_err, 1'b1);
        hold = 1'b1;
        rnd_ops();
        req_valid = 4'b0100; tick();
        req_valid = 4'b0000; tick();
        req_valid = 4'b1000; tick();
        req_valid = 4'b0000; tick();
        chk("two_outstanding", inflight, 3'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold = 1'b0;
        chk("rst_inflight", inflight, 3'd0);
        chk("rst_proto", proto_err, 1'b0);
        req_valid = 4'b1111;
        tick();
        chk("rst_prio", last_ready, 4'b0001);
        idle(10);

        // Randomized traffic with busy and hold-back
        for (int i = 0; i < 600; i++) begin
            rnd_ops();
            req_valid = 4'($urandom);
            fu_busy   = ($urandom_range(0, 4) == 0);
            hold      = ($urandom_range(0, 3) == 0);
            tick();
        end
        fu_busy = 1'b0;
        hold    = 1'b0;
        idle(20);
        chk("drain_inflight", inflight, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
